// File: rtl/tm1637_driver.sv
// tm1637_driver: two-wire TM1637 link for a 4-digit LED display.
// A start strobe sends data-cmd, address+4 digits and display-ctl frames.

module tm1637_driver #(
  parameter int TICK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  input  logic [2:0] brightness,
  input  logic       display_on,
  input  logic       tm_dio_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       tm_clk,
  output logic       tm_dio_oe
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;

  logic [7:0]    seg0_q, seg1_q, seg2_q, seg3_q;
  logic [3:0]    ctl_q;

  logic          ack_err_q, ack_err_d;
  logic          clk_q, clk_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dio_s1_q, dio_s2_q;

  logic          accept;
  logic          tick_end;
  logic          last_in_frame;
  logic [7:0]    cur_byte;

  assign accept   = start && !busy_q;
  assign tick_end = (div_q == DIV_MAX);

  // Byte 0 is frame 1, bytes 1..5 frame 2, byte 6 frame 3.
  assign last_in_frame = (byte_q == 3'd0) ||
                         (byte_q == 3'd5) ||
                         (byte_q == 3'd6);

  // Byte on the wire for the upcoming sequencer position.
  always_comb begin
    cur_byte = 8'h40;
    unique case (byte_d)
      3'd0:    cur_byte = 8'h40;
      3'd1:    cur_byte = 8'hC0;
      3'd2:    cur_byte = seg0_q;
      3'd3:    cur_byte = seg1_q;
      3'd4:    cur_byte = seg2_q;
      3'd5:    cur_byte = seg3_q;
      3'd6:    cur_byte = {4'h8, ctl_q};
      default: cur_byte = 8'h40;
    endcase
  end

  // Frame FSM and quarter-bit sequencer, advanced once per tick.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    if (accept) begin
      state_d = S_START;
      div_d   = '0;
      qtr_d   = 2'd0;
      bit_d   = 3'd0;
      byte_d  = 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: div_d = '0;
        S_DONE: begin
          state_d = S_IDLE;
          div_d   = '0;
        end
        S_START, S_BIT, S_ACK, S_STOP, S_GAP: begin
          if (!tick_end) begin
            div_d = div_q + DW'(1);
          end else begin
            div_d = '0;
            case (state_q)
              S_START: begin
                state_d = S_BIT;
                qtr_d   = 2'd0;
                bit_d   = 3'd0;
              end
              S_BIT: begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                  if (bit_q == 3'd7) begin
                    state_d = S_ACK;
                  end else begin
                    bit_d = bit_q + 3'd1;
                  end
                end
              end
              S_ACK: begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                  if (last_in_frame) begin
                    state_d = S_STOP;
                  end else begin
                    state_d = S_BIT;
                    bit_d   = 3'd0;
                    byte_d  = byte_q + 3'd1;
                  end
                end
              end
              S_STOP: begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                  state_d = S_GAP;
                end
              end
              S_GAP: begin
                if (byte_q == 3'd6) begin
                  state_d = S_DONE;
                end else begin
                  state_d = S_START;
                  byte_d  = byte_q + 3'd1;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
        default: begin
          state_d = S_IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  // Bus levels for the upcoming position; Q0 keeps DIO where it was.
  always_comb begin
    clk_d = clk_q;
    oe_d  = oe_q;
    unique case (state_d)
      S_START: begin
        clk_d = 1'b1;
        oe_d  = 1'b1;
      end
      S_BIT: begin
        clk_d = qtr_d[1];
        if (qtr_d == 2'd1) oe_d = ~cur_byte[bit_d];
      end
      S_ACK: begin
        clk_d = qtr_d[1];
        if (qtr_d == 2'd1) oe_d = 1'b0;
      end
      S_STOP: begin
        clk_d = qtr_d[1];
        if (qtr_d == 2'd1) oe_d = 1'b1;
        if (qtr_d == 2'd2) oe_d = 1'b1;
        if (qtr_d == 2'd3) oe_d = 1'b0;
      end
      default: begin
        clk_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  // Status: sticky missing-ACK, busy and the one-cycle done pulse.
  always_comb begin
    ack_err_d = ack_err_q;
    if (accept) begin
      ack_err_d = 1'b0;
    end else if (state_q == S_ACK && qtr_q == 2'd3 &&
                 tick_end && dio_s2_q) begin
      ack_err_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Sequencer, status and bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      ack_err_q <= 1'b0;
      clk_q     <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      ack_err_q <= ack_err_d;
      clk_q     <= clk_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Digit and control latch, loaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg0_q <= 8'h00;
      seg1_q <= 8'h00;
      seg2_q <= 8'h00;
      seg3_q <= 8'h00;
      ctl_q  <= 4'h0;
    end else if (accept) begin
      seg0_q <= seg0;
      seg1_q <= seg1;
      seg2_q <= seg2;
      seg3_q <= seg3;
      ctl_q  <= {display_on, brightness};
    end
  end

  // Two-flop synchronizer for the DIO pad; idles at the pulled-up level.
  always_ff @(posedge clk) begin
    if (rst) begin
      dio_s1_q <= 1'b1;
      dio_s2_q <= 1'b1;
    end else begin
      dio_s1_q <= tm_dio_in;
      dio_s2_q <= dio_s1_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign tm_clk    = clk_q;
  assign tm_dio_oe = oe_q;

endmodule

// File: tb/tb_tm1637_driver.sv
// tb_tm1637_driver: bus-level decode of the TM1637 link
// against a frame/byte reference model.

module tb_tm1637_driver;

  localparam int TD = 4;
  localparam int TOTAL = 270 * TD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seg0 = 8'h00;
  logic [7:0] seg1 = 8'h00;
  logic [7:0] seg2 = 8'h00;
  logic [7:0] seg3 = 8'h00;
  logic [2:0] brightness = 3'd0;
  logic       display_on = 1'b0;
  logic       dio_line;
  logic       busy, done, ack_err, tm_clk, tm_dio_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit ack_en = 1'b1;
  bit clr_req = 1'b0;
  bit slave_low = 1'b0;
  bit pclk = 1'b1;
  bit pdio = 1'b1;
  int nbits = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] rxq[$];
  int starts = 0;
  int stops = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  assign dio_line = ~tm_dio_oe & ~slave_low;

  tm1637_driver #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .brightness (brightness),
    .display_on (display_on),
    .tm_dio_in  (dio_line),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .tm_clk     (tm_clk),
    .tm_dio_oe  (tm_dio_oe)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Bus watcher and TM1637 slave: decodes start/stop/bytes, drives ACK.
  initial forever begin
    @(negedge clk);
    if (clr_req) begin
      starts = 0;
      stops = 0;
      busy_cnt = 0;
      done_cnt = 0;
      done_cyc = 0;
      rxq.delete();
      nbits = 0;
      slave_low = 1'b0;
      pclk = 1'b1;
      pdio = 1'b1;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pclk && tm_clk && pdio && !dio_line) begin
        starts++;
        nbits = 0;
      end else if (pclk && tm_clk && !pdio && dio_line) begin
        stops++;
      end
      if (!pclk && tm_clk) begin
        if (nbits < 8) sh[nbits[2:0]] = dio_line;
        nbits++;
        if (nbits == 9) begin
          rxq.push_back(sh);
          nbits = 0;
        end
      end
      if (pclk && !tm_clk) begin
        if (slave_low) slave_low = 1'b0;
        else if (nbits == 8 && ack_en) slave_low = 1'b1;
      end
      pclk = tm_clk;
      pdio = dio_line;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  function automatic logic [7:0] ref_byte(input int k,
      input logic [7:0] s0, input logic [7:0] s1,
      input logic [7:0] s2, input logic [7:0] s3,
      input logic [2:0] br, input logic on);
    logic [7:0] b;
    case (k)
      0: b = 8'h40;
      1: b = 8'hC0;
      2: b = s0;
      3: b = s1;
      4: b = s2;
      5: b = s3;
      default: b = 8'h80 | (on ? 8'h08 : 8'h00) | {5'd0, br};
    endcase
    return b;
  endfunction

  task automatic run_xfer(input logic [7:0] s0, input logic [7:0] s1,
      input logic [7:0] s2, input logic [7:0] s3,
      input logic [2:0] br, input logic on,
      input bit ack, input int poke, input string tag);
    int acc;
    bit found;
    logic [7:0] got;
    mon_clear();
    seg0 = s0; seg1 = s1; seg2 = s2; seg3 = s3;
    brightness = br;
    display_on = on;
    ack_en = ack;
    step();
    start = 1'b1;
    acc = cyc;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (poke > 0 && (cyc - acc) == poke) begin
        seg0 = ~s0; seg1 = ~s1; seg2 = ~s2; seg3 = ~s3;
        brightness = ~br;
        display_on = ~on;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt > 0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    start = 1'b0;
    repeat (5) step();
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    chk({tag, "_done_cyc"}, done_cyc - acc, TOTAL + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_cnt"}, busy_cnt, TOTAL);
    chk({tag, "_starts"}, starts, 3);
    chk({tag, "_stops"}, stops, 3);
    chk({tag, "_nbytes"}, rxq.size(), 7);
    for (int k = 0; k < 7; k++) begin
      got = (k < rxq.size()) ? rxq[k] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, got},
          {24'd0, ref_byte(k, s0, s1, s2, s3, br, on)});
    end
    chk({tag, "_ack_err"}, 32'(ack_err), 32'(!ack));
    chk({tag, "_idle_clk"}, 32'(tm_clk), 32'd1);
    chk({tag, "_idle_oe"}, 32'(tm_dio_oe), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    int acc;
    logic [7:0] r0, r1, r2, r3;
    logic [2:0] rb;
    logic ro;
    bit ra;

    repeat (3) step();
    chk("rst_clk", 32'(tm_clk), 32'd1);
    chk("rst_oe", 32'(tm_dio_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tm_clk !== 1'b1 || tm_dio_oe !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_bad_samples", bad, 0);

    run_xfer(8'h3F, 8'h06, 8'h5B, 8'h4F, 3'd7, 1'b1, 1'b1, 0, "full");
    run_xfer(8'h3F, 8'h06, 8'h5B, 8'h4F, 3'd7, 1'b1, 1'b0, 0, "noack");
    run_xfer(8'h66, 8'h6D, 8'h7D, 8'h07, 3'd2, 1'b1, 1'b1, 0, "reack");
    run_xfer(8'hBF, 8'h06, 8'h5B, 8'h4F, 3'd3, 1'b0, 1'b1, 0, "dispoff");
    run_xfer(8'h12, 8'h34, 8'h56, 8'h78, 3'd5, 1'b1, 1'b1, 100, "ignore");

    for (int t = 0; t < 3; t++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      rb = 3'($urandom_range(0, 7));
      ro = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      run_xfer(r0, r1, r2, r3, rb, ro, ra, 0, $sformatf("rnd%0d", t));
    end

    mon_clear();
    seg0 = 8'($urandom);
    ack_en = 1'b1;
    step();
    start = 1'b1;
    acc = cyc;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && (cyc - acc) < 257; i++) step();
    chk("mid_cyc", cyc - acc, 257);
    chk("mid_clk", 32'(tm_clk), 32'd0);
    chk("mid_oe", 32'(tm_dio_oe), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_clk", 32'(tm_clk), 32'd1);
    chk("mid_rst_oe", 32'(tm_dio_oe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    step();

    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("rst_wins_busy", 32'(busy), 32'd0);

    run_xfer(8'h6F, 8'h77, 8'h7C, 8'h39, 3'd6, 1'b1, 1'b1, 0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm1637_driver.md
# tm1637_driver

Serial link stage that takes four segment bytes from the per-digit `dec_to_seg` decoders and writes them to a TM1637 4-digit LED controller over its two-wire bus (CLK + open-drain DIO). On a start strobe it latches the digits and brightness and sends three frames: data command, address-plus-4-data, display control. It reports busy/done and a sticky missing-ACK flag. The block is sequential only: tick divider, bit/phase sequencer and frame FSM.

## Interface
- `TICK_DIV`, 125: system clocks per quarter-bit tick; must be ≥ 2. At 50 MHz this gives a 100 kHz bit rate.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Accepted only when `busy`=0.
- `seg0`..`seg3` in 8 each: digit patterns; bit7 = DP, bits6:0 = g..a. `seg0` is the leftmost digit.
- `brightness` in 3: pulse-width level 0–7.
- `display_on` in 1: display enable bit.
- `tm_dio_in` in 1: DIO pad input (asynchronous).
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `ack_err` out 1: sticky flag; at least one byte received no ACK.
- `tm_clk` out 1: bus clock, driven push-pull.
- `tm_dio_oe` out 1: 1 pulls DIO low, 0 releases it (pull-up gives 1).

## Operation
- Reset state: `tm_clk`=1, `tm_dio_oe`=0, `busy`=0, `done`=0, `ack_err`=0. FSM is IDLE, divider is 0.
- Accept (`start`=1 while `busy`=0):
  - Latch `seg0..3`, `brightness`, `display_on`.
  - Clear `ack_err`.
  - Restart the divider and enter the START state of frame 1.
  - `start` while busy is ignored.
- Frames:
  - F1: 0x40 (write data, auto-increment).
  - F2: 0xC0, then seg0, seg1, seg2, seg3.
  - F3: 0x80 | {display_on, brightness}, i.e. 0x88 | brightness when on.
- Each frame runs START → bytes → STOP → GAP.
- Bytes go out LSB first, 8 data bits then 1 ACK bit.
- FSM states: IDLE, START, BIT, ACK, STOP, GAP, DONE.
- START is 1 tick: `tm_clk`=1, `tm_dio_oe`=1.
- BIT/ACK is 4 ticks per bit:
  - Q0: `tm_clk`=0, DIO unchanged.
  - Q1: `tm_clk`=0; DIO set to the bit (oe = ~bit). In ACK, oe=0.
  - Q2: `tm_clk`=1.
  - Q3: `tm_clk`=1.
- ACK sampling:
  - `tm_dio_in` passes through a 2-flop synchronizer.
  - The synchronized value is sampled on the last cycle of ACK Q3.
  - Sampled 1 sets `ack_err`.
  - A missing ACK does not abort the transfer.
- STOP is 4 ticks:
  - Q0: clk 0.
  - Q1: clk 0, oe=1.
  - Q2: clk 1, oe=1.
  - Q3: clk 1, oe=0 (the rising DIO is the stop condition).
- GAP is 1 tick with clk 1, oe 0.
- After F3's GAP: DONE for one cycle (`done`=1, `busy`=0), then IDLE.
- `tm_clk` and `tm_dio_oe` change only on tick boundaries. Data never changes while `tm_clk`=1, except at START and STOP.

## Timing
- All outputs are registered. The accept edge is cycle 0, and tick 0 outputs appear from cycle 1.
- Each tick lasts exactly `TICK_DIV` cycles.
- Ticks per frame = 1 + 36·bytes + 4 + 1, giving F1=42, F2=186, F3=42; total 270 ticks.
- `busy`=1 for cycles 1 .. 270·TICK_DIV.
- `done`=1 only at cycle 270·TICK_DIV+1.
- Earliest next accept is the `done` cycle.
- `rst` mid-transfer returns to the reset state on the next edge. The bus is released with no stop condition.
- `start` and `rst` together: `rst` wins.

## Test plan
- **Reset/idle:** hold `rst` for 3 cycles, then idle for 50 cycles → `tm_clk`=1, `tm_dio_oe`=0, `busy`=0, no `done`.
- **Full frame decode:** `TICK_DIV`=4; seg=0x3F/0x06/0x5B/0x4F, brightness=7, on=1; bus model ACKs every byte.
  - Decoded bytes must be 0x40 | 0xC0,3F,06,5B,4F | 0x8F.
  - Exactly 3 start and 3 stop conditions.
  - `done` at cycle 1081.
  - `ack_err`=0.
- **Missing ACK:** model never ACKs → all 7 bytes still sent, `done` on time, `ack_err`=1. A second start with ACKs present clears it to 0.
- **Display off / DP:** on=0, brightness=3, seg0=0xBF → last byte 0x83, first data byte 0xBF.
- **Busy ignore:** pulse `start` at cycle 100 with different segs → no effect; sent bytes match the first latch; only one `done`.
- **Reset mid-transfer:** `rst` during F2 bit 5 → next cycle `tm_clk`=1, `tm_dio_oe`=0, `busy`=0. A fresh start then completes a full, correct 270-tick transfer.
